// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO,
// single-cycle MTHI/MTLO writes and combinational MFHI/MFLO read mux.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Result packed as {write_enable, hi, lo}; a zero divisor leaves HI/LO untouched.
  function automatic logic [64:0] md_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] squo;
    logic signed [31:0] srem;
    logic [64:0]        res;
    sprod = 64'sd0;
    uprod = 64'd0;
    squo  = 32'sd0;
    srem  = 32'sd0;
    res   = {1'b0, 32'd0, 32'd0};
    case (op)
      OP_MULT: begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res   = {1'b1, sprod[63:0]};
      end
      OP_MULTU: begin
        uprod = {32'd0, a} * {32'd0, b};
        res   = {1'b1, uprod};
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {1'b0, 32'd0, 32'd0};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // Overflowing quotient wraps to the dividend, remainder zero.
          res = {1'b1, 32'd0, 32'h8000_0000};
        end else begin
          squo = $signed(a) / $signed(b);
          srem = $signed(a) % $signed(b);
          res  = {1'b1, srem, squo};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res = {1'b0, 32'd0, 32'd0};
        end else begin
          res = {1'b1, a % b, a / b};
        end
      end
      default: res = {1'b0, 32'd0, 32'd0};
    endcase
    return res;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       op_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [64:0]      calc_s;
  logic             start_ok_s;
  logic [CNT_W-1:0] load_s;

  assign calc_s     = md_calc(op_r, a_r, b_r);
  assign start_ok_s = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign load_s     = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;

  // Operation sequencing, HI/LO writeback and move handling; busy blocks starts and moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      busy  <= 1'b0;
      op_r  <= OP_NONE;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (busy) begin
      if (cnt_r == CNT_ONE) begin
        cnt_r <= {CNT_W{1'b0}};
        busy  <= 1'b0;
        if (calc_s[64]) begin
          hi <= calc_s[63:32];
          lo <= calc_s[31:0];
        end
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else if (start_ok_s) begin
      op_r  <= md_op;
      a_r   <= rs_d;
      b_r   <= rt_d;
      cnt_r <= load_s;
      busy  <= 1'b1;
    end else if (md_op == OP_MTHI) begin
      hi <= rs_d;
    end else if (md_op == OP_MTLO) begin
      lo <= rs_d;
    end
  end

  // MFHI/MFLO read mux; no bypass of a same-edge write.
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      OP_MFHI: md_out = hi;
      OP_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a timestamp-based HI/LO model checked every negedge,
// plus hand-computed literal expectations for the documented scenarios.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_d  = 32'd0;
  logic [31:0] rt_d  = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_pass   = 0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_d(rs_d), .rt_d(rt_d), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic with wide integers: {write_enable, hi, lo}
  function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 64'd0; q = 64'd0; rm = 64'd0;
    case (op)
      OP_MULT:  begin r = 64'(sa * sb); return {1'b1, r}; end
      OP_MULTU: begin r = {32'd0, a} * {32'd0, b}; return {1'b1, r}; end
      OP_DIV: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = 64'(sa / sb); rm = 64'(sa % sb);
        return {1'b1, rm[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = {32'd0, a} / {32'd0, b}; rm = {32'd0, a} % {32'd0, b};
        return {1'b1, rm[31:0], q[31:0]};
      end
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  // Model: busy is "current cycle index before the completion stamp".
  int          cyc = 0;
  int          done_cyc = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        p_we = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; done_cyc <= 0; m_hi <= 32'd0; m_lo <= 32'd0;
      p_we <= 1'b0; p_hi <= 32'd0; p_lo <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (cyc < done_cyc) begin
        if ((cyc + 1 == done_cyc) && p_we) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end else if (start && (md_op >= OP_MULT) && (md_op <= OP_DIVU)) begin
        done_cyc <= cyc + 1 + ((md_op <= OP_MULTU) ? MC : DC);
        {p_we, p_hi, p_lo} <= ref_result(md_op, rs_d, rt_d);
      end else if (md_op == OP_MTHI) begin
        m_hi <= rs_d;
      end else if (md_op == OP_MTLO) begin
        m_lo <= rs_d;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    logic [31:0] exp_md;
    exp_md = (md_op == OP_MFHI) ? m_hi : (md_op == OP_MFLO) ? m_lo : 32'd0;
    chk("busy",   {31'd0, busy}, {31'd0, (cyc < done_cyc)});
    chk("hi",     hi, m_hi);
    chk("lo",     lo, m_lo);
    chk("md_out", md_out, exp_md);
  end

  task automatic drv(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    #1;
    start = st; md_op = op; rs_d = a; rt_d = b;
  endtask

  task automatic wait_busy(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int exp_n);
    drv(1'b1, op, a, b);
    @(posedge clk);
    #1;
    start = 1'b0; md_op = OP_NONE;
    wait_busy(name, exp_n);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // async reset mid-cycle
    drv(1'b0, OP_MTHI, 32'h0000_AAAA, 32'd0);
    drv(1'b0, OP_MTLO, 32'h0000_BBBB, 32'd0);
    drv(1'b0, OP_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #1 reset = 1'b0;

    run_op("mult_busy", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op("div_busy", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op("divu_busy", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 10);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'd1);

    run_op("divovf_busy", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // divide by zero preserves preloaded HI/LO
    drv(1'b0, OP_MTHI, 32'h0000_1234, 32'd0);
    drv(1'b0, OP_MTLO, 32'h0000_5678, 32'd0);
    run_op("div0_busy", OP_DIV, 32'd100, 32'd0, 10);
    chk("div0_hi", hi, 32'h0000_1234);
    chk("div0_lo", lo, 32'h0000_5678);
    md_op = OP_MFHI;
    #1 chk("div0_mfhi", md_out, 32'h0000_1234);
    md_op = OP_MFLO;
    #1 chk("div0_mflo", md_out, 32'h0000_5678);

    // start and MTLO while busy are ignored
    drv(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 start = 1'b0; md_op = OP_NONE;
    drv(1'b1, OP_DIV, 32'd7, 32'd7);
    drv(1'b0, OP_MTLO, 32'h0000_DEAD, 32'd0);
    drv(1'b0, OP_NONE, 32'd0, 32'd0);
    wait_busy("multu_busy_rest", 2);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'd1);

    // start with a non-arithmetic op is ignored
    drv(1'b1, OP_MFLO, 32'd9, 32'd9);
    drv(1'b0, OP_NONE, 32'd0, 32'd0);

    // held start: accepted one edge after busy falls
    drv(1'b1, OP_MULT, 32'd5, 32'd6);
    @(posedge clk);
    #1 rs_d = 32'd3; rt_d = 32'd4;
    wait_busy("b2b_first", 5);
    chk("b2b_first_lo", lo, 32'd30);
    @(posedge clk);
    #1 start = 1'b0; md_op = OP_NONE;
    wait_busy("b2b_second", 5);
    chk("b2b_second_lo", lo, 32'd12);
    chk("b2b_second_hi", hi, 32'd0);

    // reset in the middle of a DIV abandons it
    drv(1'b1, OP_DIV, 32'd100, 32'd7);
    @(posedge clk);
    #1 start = 1'b0; md_op = OP_NONE;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
